rd_frame_packer: RTL
====================

Name: rd_frame_packer

Overview:
- Read-clock-domain stage directly downstream of the dual-memory low-to-high speed transfer path.
- Accepts 32-bit words read out of the memory path on rclk and buffers them in a small FIFO.
- Emits them to the high-speed consumer as framed bursts: header word, FRAME_LEN data words, checksum word.
- Valid/ready handshake on both sides; applies backpressure to the memory read enable.

Parameters:
- DATA_WIDTH, 32, word width; must be >= 32.
- FRAME_LEN, 8, data words per frame, 1..255.
- ADD_WIDTH, 2, FIFO address width; FIFO depth = 2**ADD_WIDTH (4).

Ports:
- rclk  input  1  read-side clock, the single clock of this block
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- din  input  DATA_WIDTH  word from memory read path
- din_valid  input  1  din carries a word this cycle
- din_ready  output  1  block can accept a word; drives upstream ren
- dout  output  DATA_WIDTH  framed output word
- dout_valid  output  1  dout holds a word
- dout_ready  input  1  consumer accepts dout this cycle
- dout_sof  output  1  dout is a header word
- dout_eof  output  1  dout is a checksum word
- frame_cnt  output  16  completed frames, wraps at 65535 -> 0
- ovf_err  output  1  sticky: din_valid seen while din_ready = 0

Behaviour:
Reset (rst = 0, asynchronous):
- FIFO is emptied; FSM goes to IDLE.
- dout, checksum and data-word counter are 0; dout_valid, dout_sof, dout_eof and ovf_err are 0; frame_cnt is 0.
- din_ready is 1 one edge after rst deasserts. It is 0 while rst = 0.
- Reset mid-frame discards the partial frame. No checksum is emitted.

FIFO:
- din_ready = (count != DEPTH), combinational from registered count.
- Push happens on a rclk edge when din_valid && din_ready.
- Pop happens when the FSM loads a data word into the output register.
- Simultaneous push and pop leaves count unchanged and keeps data order.
- When full, no push occurs even if a pop happens on the same edge.

Output register:
- A load is allowed when (!dout_valid || dout_ready).
- When a load is not allowed, dout, dout_sof and dout_eof hold stable.

FSM states and transitions:
- IDLE: on an edge with count != 0 and a load allowed, load header {16'hA5A5, frame_cnt}, upper bits zero-extended. Set dout_sof = 1 and dout_valid = 1, then go to HDR.
- HDR / DATA:
  - With a load allowed and count != 0: pop the FIFO head into dout, set dout_valid = 1 and sof = eof = 0, add the word to the checksum (mod 2**DATA_WIDTH), and increment the word counter.
  - After FRAME_LEN pops, go to CSUM.
  - With a load allowed and count == 0: dout_valid = 0 (bubble); stay in the same state.
- CSUM: when a load is allowed, load the checksum. Set dout_eof = 1 and dout_valid = 1, then go to WAIT.
- WAIT: when dout_ready = 1, increment frame_cnt, clear the checksum and word counter, and clear dout_valid and dout_eof. Then go to IDLE.

Timing, latency and errors:
- Latency: a word pushed at edge k (FIFO previously empty, frame start) gives header valid after edge k+1. The data word becomes valid after edge k+2, provided the header is accepted at edge k+2.
- In mid-frame, a word pushed at edge k into an empty FIFO is valid on dout after edge k+1.
- ovf_err sets on any edge with din_valid = 1 and din_ready = 0. It clears only on reset.
- Checksum wraps modulo 2**DATA_WIDTH. The header and checksum words are excluded from it.

Test Plan:
- Reset then idle: rst = 0 for 3 edges, then 1; din_valid = 0 -> dout_valid = 0, frame_cnt = 0, din_ready = 1 one edge after release, ovf_err = 0.
- Single frame, no backpressure: push 1..8 back-to-back, dout_ready = 1 -> dout sequence 32'hA5A50000 (sof), 1..8, 32'h00000024 (eof). frame_cnt = 1 after the checksum is accepted.
- Backpressure/full: dout_ready = 0, push 6 words back-to-back -> 4 accepted, din_ready = 0 after 4th push, header held stable. A 5th din_valid at full sets ovf_err = 1.
- Checksum wrap and sequence: two frames of 8 x 32'hFFFFFFFF -> checksum 32'hFFFFFFF8 each. Second header = 32'hA5A50001; frame_cnt = 2.
- Bubbles: feed one word every 3 rclk cycles -> dout_valid drops between data words, no word lost or duplicated, checksum still correct.
- Reset mid-frame: assert rst after the 4th data word is accepted -> outputs clear immediately. The next frame starts with header 32'hA5A50000 and a fresh checksum.

Source files
------------

// File: rtl/rd_frame_packer.sv
// Read-clock-domain frame packer: buffers memory read words in a small FIFO and
// emits header / FRAME_LEN data words / checksum bursts over a valid/ready port.
module rd_frame_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 8,
  parameter int ADD_WIDTH  = 2
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sof,
  output logic                  dout_eof,
  output logic [15:0]           frame_cnt,
  output logic                  ovf_err
);

  localparam int DEPTH = 1 << ADD_WIDTH;
  localparam logic [ADD_WIDTH:0] FULL_C = {1'b1, {ADD_WIDTH{1'b0}}};
  localparam logic [7:0]         LAST_C = 8'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    WAIT = 3'd4
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] csum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc + word;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADD_WIDTH-1:0]  wptr_r, rptr_r;
  logic [ADD_WIDTH:0]    count_r;
  logic                  rdy_en_r, ovf_r;
  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] dout_r, dout_s, csum_r, csum_s, hdr_s;
  logic                  valid_r, valid_s, sof_r, sof_s, eof_r, eof_s;
  logic [7:0]            wcnt_r, wcnt_s;
  logic [15:0]           frame_cnt_r, frame_cnt_s;
  logic                  push_s, pop_s, load_ok_s, have_s;

  // din_ready stays low until the first edge after reset release
  assign din_ready = rdy_en_r && (count_r != FULL_C);
  assign push_s    = din_valid && din_ready;
  assign load_ok_s = !valid_r || dout_ready;
  assign have_s    = (count_r != {(ADD_WIDTH+1){1'b0}});

  // FIFO storage, pointers, occupancy, ready enable and sticky overflow flag
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DATA_WIDTH{1'b0}};
      wptr_r   <= {ADD_WIDTH{1'b0}};
      rptr_r   <= {ADD_WIDTH{1'b0}};
      count_r  <= {(ADD_WIDTH+1){1'b0}};
      rdy_en_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (push_s) begin
        mem_r[wptr_r] <= din;
        wptr_r        <= wptr_r + 1'b1;
      end
      if (pop_s) rptr_r <= rptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (din_valid && !din_ready) ovf_r <= 1'b1;
    end
  end

  // Framing FSM: next state and next output-register contents
  always_comb begin
    state_s     = state_r;
    dout_s      = dout_r;
    valid_s     = valid_r;
    sof_s       = sof_r;
    eof_s       = eof_r;
    csum_s      = csum_r;
    wcnt_s      = wcnt_r;
    frame_cnt_s = frame_cnt_r;
    pop_s       = 1'b0;
    hdr_s       = {DATA_WIDTH{1'b0}};
    hdr_s[31:0] = {16'hA5A5, frame_cnt_r};
    case (state_r)
      IDLE: begin
        if (have_s && load_ok_s) begin
          dout_s  = hdr_s;
          sof_s   = 1'b1;
          eof_s   = 1'b0;
          valid_s = 1'b1;
          state_s = HDR;
        end else begin
          state_s = IDLE;
        end
      end
      HDR, DATA: begin
        if (load_ok_s && have_s) begin
          pop_s   = 1'b1;
          dout_s  = mem_r[rptr_r];
          valid_s = 1'b1;
          sof_s   = 1'b0;
          eof_s   = 1'b0;
          csum_s  = csum_add(csum_r, mem_r[rptr_r]);
          wcnt_s  = wcnt_r + 8'd1;
          state_s = (wcnt_r == LAST_C) ? CSUM : DATA;
        end else if (load_ok_s) begin
          // FIFO ran dry mid-frame: emit a bubble and keep waiting
          valid_s = 1'b0;
          sof_s   = 1'b0;
          eof_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      CSUM: begin
        if (load_ok_s) begin
          dout_s  = csum_r;
          sof_s   = 1'b0;
          eof_s   = 1'b1;
          valid_s = 1'b1;
          state_s = WAIT;
        end else begin
          state_s = CSUM;
        end
      end
      WAIT: begin
        if (dout_ready) begin
          frame_cnt_s = frame_cnt_r + 16'd1;
          csum_s      = {DATA_WIDTH{1'b0}};
          wcnt_s      = 8'd0;
          valid_s     = 1'b0;
          eof_s       = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        sof_s   = 1'b0;
        eof_s   = 1'b0;
      end
    endcase
  end

  // FSM state and registered output port
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      dout_r      <= {DATA_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      sof_r       <= 1'b0;
      eof_r       <= 1'b0;
      csum_r      <= {DATA_WIDTH{1'b0}};
      wcnt_r      <= 8'd0;
      frame_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_s;
      dout_r      <= dout_s;
      valid_r     <= valid_s;
      sof_r       <= sof_s;
      eof_r       <= eof_s;
      csum_r      <= csum_s;
      wcnt_r      <= wcnt_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = valid_r;
  assign dout_sof   = sof_r;
  assign dout_eof   = eof_r;
  assign frame_cnt  = frame_cnt_r;
  assign ovf_err    = ovf_r;

endmodule
